// File: rtl/mioc_resp_capture.sv
// MIOC response capture: settle, sample q/qbar, check, queue result records.
// Keeps saturating vector/error counters and a sticky illegal-state flag.
module mioc_resp_capture #(
    parameter int SETTLE_CYCLES = 4,
    parameter int DEPTH         = 8,
    parameter int CNT_W         = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_vec_valid,
    output logic             o_vec_ready,
    input  logic [3:0]       i_vec_pat,
    input  logic [1:0]       i_vec_exp,
    input  logic             i_dut_q,
    input  logic             i_dut_qbar,
    output logic             o_rec_valid,
    input  logic             i_rec_ready,
    output logic [8:0]       o_rec_data,
    output logic [CNT_W-1:0] o_vec_count,
    output logic [CNT_W-1:0] o_err_count,
    output logic             o_illegal
);

    localparam int              AW        = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [7:0]      SETTLE_LD = 8'(SETTLE_CYCLES);
    localparam logic [AW:0]     FULL_OCC  = (AW+1)'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        S_IDLE,
        S_SETTLE
    } state_t;

    state_t          r_state;
    state_t          w_state_nxt;
    logic [7:0]      r_cnt;
    logic [3:0]      r_pat;
    logic [1:0]      r_exp;
    logic [8:0]      r_mem [DEPTH];
    logic [AW-1:0]   r_wr_ptr;
    logic [AW-1:0]   r_rd_ptr;
    logic [AW:0]     r_occ;
    logic [CNT_W-1:0] r_vec_count;
    logic [CNT_W-1:0] r_err_count;
    logic            r_illegal;

    logic            w_full;
    logic            w_vec_ready;
    logic            w_accept;
    logic            w_push;
    logic            w_pop;
    logic [1:0]      w_sample;
    logic            w_mis;
    logic [8:0]      w_rec;

    assign w_full   = (r_occ == FULL_OCC);
    assign w_accept = i_vec_valid && w_vec_ready;
    assign w_push   = (r_state == S_SETTLE) && (r_cnt == 8'd1);
    assign w_pop    = o_rec_valid && i_rec_ready;
    assign w_sample = {i_dut_q, i_dut_qbar};
    assign w_mis    = (w_sample != r_exp);
    assign w_rec    = {r_pat, w_sample, r_exp, w_mis};

    assign o_vec_ready = w_vec_ready;
    assign o_rec_valid = (r_occ != '0);
    assign o_rec_data  = o_rec_valid ? r_mem[r_rd_ptr] : 9'd0;
    assign o_vec_count = r_vec_count;
    assign o_err_count = r_err_count;
    assign o_illegal   = r_illegal;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Next state and handshake ready; ready held low during reset
    always_comb begin
        w_state_nxt = r_state;
        w_vec_ready = 1'b0;
        unique case (r_state)
            S_IDLE: begin
                w_vec_ready = !w_full && !i_rst;
                if (i_vec_valid && w_vec_ready) w_state_nxt = S_SETTLE;
            end
            S_SETTLE: begin
                if (r_cnt == 8'd1) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Latch the accepted vector and run the settle countdown
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cnt <= 8'd0;
            r_pat <= 4'd0;
            r_exp <= 2'd0;
        end else if (w_accept) begin
            r_cnt <= SETTLE_LD;
            r_pat <= i_vec_pat;
            r_exp <= i_vec_exp;
        end else if (r_state == S_SETTLE) begin
            r_cnt <= r_cnt - 8'd1;
        end
    end

    // Record storage; contents are only visible when occupancy is nonzero
    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr] <= w_rec;
    end

    // FIFO pointers and occupancy; push can never hit a full FIFO
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_occ    <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            if (w_push && !w_pop)      r_occ <= r_occ + 1'b1;
            else if (!w_push && w_pop) r_occ <= r_occ - 1'b1;
        end
    end

    // Saturating counters and sticky illegal flag, updated on push
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_vec_count <= '0;
            r_err_count <= '0;
            r_illegal   <= 1'b0;
        end else if (w_push) begin
            if (r_vec_count != CNT_MAX)
                r_vec_count <= r_vec_count + 1'b1;
            if (w_mis && (r_err_count != CNT_MAX))
                r_err_count <= r_err_count + 1'b1;
            if (i_dut_q == i_dut_qbar)
                r_illegal <= 1'b1;
        end
    end

endmodule

// File: doc/mioc_resp_capture.md
Name: mioc_resp_capture

Overview:
Synthesizable response-capture and check block for MIOC register test. It is the receive end of the pattern-drive path.
- Each time a 4-bit stimulus pattern is applied to the device under test, the block waits a fixed settle time and samples q/qbar.
- It compares the sample against the expected values and pushes a result record into a FIFO, which is read out over a ready/valid port.
- It keeps vector and error counters for pass/fail reporting.

Parameters:
SETTLE_CYCLES, 4, clock edges from vector acceptance to q/qbar sample; legal range 1..255.
DEPTH, 8, result FIFO entries; power of 2, at least 2.
CNT_W, 16, width of vec_count and err_count.

Ports:
clk  in  1  single clock, rising edge.
rst  in  1  asynchronous, active-high reset.
vec_valid  in  1  stimulus vector offered.
vec_ready  out  1  block can accept a vector.
vec_pat  in  4  applied pattern, {in1,in2,in3,in4}.
vec_exp  in  2  expected {q,qbar}.
dut_q  in  1  device output q, already synchronized to clk.
dut_qbar  in  1  device output qbar, already synchronized to clk.
rec_valid  out  1  result record available at the FIFO head.
rec_ready  in  1  consumer takes the head record.
rec_data  out  9  {pat[3:0], q, qbar, exp_q, exp_qbar, mismatch}.
vec_count  out  CNT_W  vectors sampled, saturating.
err_count  out  CNT_W  mismatching vectors, saturating.
illegal  out  1  sticky flag: a sample had q==qbar.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE, FIFO empty (rd_ptr=wr_ptr=0, occupancy 0).
  - rec_valid=0, rec_data=0, vec_count=0, err_count=0, illegal=0.
  - vec_ready=0 while rst is high.
- States:
  - IDLE: vec_ready = !fifo_full.
    - On vec_valid && vec_ready, latch vec_pat and vec_exp, load settle counter with SETTLE_CYCLES, go to SETTLE.
  - SETTLE: vec_ready=0; the counter decrements once per edge.
    - On the edge where the counter goes 1->0, the block samples dut_q/dut_qbar, forms the record, pushes it into the FIFO and returns to IDLE.
    - The sample is taken on the SETTLE_CYCLES-th edge after the accept edge.
- Latency and throughput:
  - Accept at edge E, sample and push at edge E+SETTLE_CYCLES.
  - rec_valid rises after that edge if the FIFO was empty.
  - vec_ready is high again in the cycle after the push.
  - Maximum throughput is one vector per SETTLE_CYCLES+1 cycles.
- Record contents:
  - mismatch = ({q,qbar} != exp).
  - The record also holds the latched pattern and expected bits.
- Counters and flags, updated on the push edge:
  - vec_count increments.
  - err_count increments if mismatch.
  - Both hold at 2^CNT_W-1 (saturate, no wrap).
  - illegal sets when sampled q==qbar and clears only on reset.
- FIFO:
  - First-word-fall-through: rec_data is valid whenever rec_valid=1 and is stable until popped.
  - Pop on rec_valid && rec_ready.
  - Pointers wrap modulo DEPTH; full when occupancy==DEPTH.
  - At most one record is outstanding, and a vector is accepted only when not full, so a push never meets a full FIFO. No overflow path is needed.
  - Simultaneous push and pop: both take effect, occupancy unchanged.
  - A pop from an empty FIFO is ignored; rec_ready is don't-care when rec_valid=0.
- Reset mid-SETTLE: the in-flight vector is discarded, no record is written, and counters are cleared.
- vec_pat and vec_exp may change freely after the accept edge; only the latched copies are used.

Test Plan:
1. Reset, then SETTLE_CYCLES=4, send pat=4'b1010 exp=2'b10, hold dut_q=1 dut_qbar=0 -> rec_valid rises 4 edges after accept; rec_data=9'b1010_10_10_0; vec_count=1, err_count=0.
2. Send pat=4'b0110 exp=2'b01 with dut_q=1 dut_qbar=0 -> mismatch=1, rec_data=9'b0110_10_01_1, err_count=1. Drive dut_q=dut_qbar=1 on the sample edge of the next vector -> illegal=1, and it stays 1 through later passing vectors.
3. Hold rec_ready=0 and send DEPTH=8 vectors -> vec_ready=0 after the 8th push and a 9th vec_valid is not accepted. Pop one -> vec_ready=1 next cycle. Then pop all 8 -> records come out in order; rec_valid falls after the last pop.
4. rec_ready=1 continuously with back-to-back vec_valid -> accepts spaced 5 cycles apart; each record popped the cycle it appears; occupancy never exceeds 1.
5. CNT_W=4, 17 mismatching vectors -> vec_count and err_count saturate at 15.
6. Assert rst 2 cycles into SETTLE -> rec_valid=0, counters=0, no record after release; the next vector behaves as in scenario 1.
